// File: rtl/aes_pkg.sv
// Shared constants and types for the AES datapath blocks.
//   BLOK_W              : AES block width in bits.
//   VARSAYILAN_DERINLIK : default block buffer depth (shared with aes_engine and the wrapper).
//   fifo_durum_t        : input buffer state, BEKLE (fill) or AKIS (stream).
package aes_pkg;

    localparam int unsigned BLOK_W              = 128;
    localparam int unsigned VARSAYILAN_DERINLIK = 16;

    typedef enum logic {
        BEKLE = 1'b0,
        AKIS  = 1'b1
    } fifo_durum_t;

endpackage

// File: rtl/aes_fifo_bellek.sv
// Simple dual-port block storage: synchronous write, asynchronous read, so it can map
// onto distributed RAM.
// Ports:
//   clk      : clock, write on rising edge
//   yaz_en   : write enable
//   yaz_adr  : write address
//   yaz_veri : write data
//   oku_adr  : read address
//   oku_veri : read data (combinational from oku_adr)
module aes_fifo_bellek #(
    parameter int unsigned DERINLIK = 16,
    parameter int unsigned GENISLIK = 128
) (
    input  logic                        clk,
    input  logic                        yaz_en,
    input  logic [$clog2(DERINLIK)-1:0] yaz_adr,
    input  logic [GENISLIK-1:0]         yaz_veri,
    input  logic [$clog2(DERINLIK)-1:0] oku_adr,
    output logic [GENISLIK-1:0]         oku_veri
);

    logic [GENISLIK-1:0] mem [DERINLIK];

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (yaz_en) begin
            mem[yaz_adr] <= yaz_veri;
        end
    end

    assign oku_veri = mem[oku_adr];

endmodule

// File: rtl/aes_giris_fifo.sv
// Input block buffer ahead of aes_engine. Collects plaintext blocks until full (or until a
// flush request), then streams them to the engine with a valid/ready handshake.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   yaz_blok    : producer block
//   yaz_gecerli : producer valid
//   yaz_hazir   : buffer can accept a block (not full, not in reset)
//   bosalt      : single-cycle flush request, starts streaming a partial buffer
//   blok        : head block (first-word fall-through)
//   g_gecerli   : head block valid towards the engine
//   hazir       : engine accepts the head block
//   seviye      : current occupancy
module aes_giris_fifo
    import aes_pkg::*;
#(
    parameter int unsigned DERINLIK = VARSAYILAN_DERINLIK,
    parameter int unsigned GENISLIK = BLOK_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [GENISLIK-1:0]           yaz_blok,
    input  logic                          yaz_gecerli,
    output logic                          yaz_hazir,
    input  logic                          bosalt,
    output logic [GENISLIK-1:0]           blok,
    output logic                          g_gecerli,
    input  logic                          hazir,
    output logic [$clog2(DERINLIK+1)-1:0] seviye
);

    localparam int unsigned AW = $clog2(DERINLIK);
    localparam int unsigned SW = $clog2(DERINLIK + 1);
    localparam logic [SW-1:0] DOLU = SW'(DERINLIK);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [SW-1:0] seviye_q, seviye_d;
    fifo_durum_t   durum_q, durum_d;
    logic          yaz, oku;

    // Both handshakes are gated by rst so nothing is accepted on a reset edge. yaz_hazir
    // looks only at the registered level: a pop cannot free space for a same-cycle write.
    assign yaz_hazir = ~rst & (seviye_q != DOLU);
    assign g_gecerli = ~rst & (durum_q == AKIS) & (seviye_q != '0);
    assign yaz       = yaz_gecerli & yaz_hazir;
    assign oku       = g_gecerli & hazir;
    assign seviye    = seviye_q;

    always_comb begin
        seviye_d = seviye_q + SW'(yaz) - SW'(oku);
        durum_d  = durum_q;
        unique case (durum_q)
            BEKLE: begin
                if (seviye_d == DOLU) begin
                    durum_d = AKIS;
                end else if (bosalt && (seviye_d != '0)) begin
                    durum_d = AKIS;
                end
            end
            AKIS: begin
                // A write alongside the last read keeps us streaming.
                if (seviye_d == '0) begin
                    durum_d = BEKLE;
                end
            end
            default: durum_d = BEKLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            durum_q  <= BEKLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            seviye_q <= '0;
        end else begin
            durum_q  <= durum_d;
            seviye_q <= seviye_d;
            if (yaz) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (oku) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    aes_fifo_bellek #(
        .DERINLIK (DERINLIK),
        .GENISLIK (GENISLIK)
    ) u_bellek (
        .clk      (clk),
        .yaz_en   (yaz),
        .yaz_adr  (wr_ptr_q),
        .yaz_veri (yaz_blok),
        .oku_adr  (rd_ptr_q),
        .oku_veri (blok)
    );

endmodule

// File: tb/tb_aes_giris_fifo.sv
// Directed and constrained-random bench for aes_giris_fifo (depth 16, width 128).
module tb_aes_giris_fifo;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] yaz_blok;
    logic         yaz_gecerli;
    logic         yaz_hazir;
    logic         bosalt;
    logic [127:0] blok;
    logic         g_gecerli;
    logic         hazir;
    logic [4:0]   seviye;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    aes_giris_fifo #(
        .DERINLIK (16),
        .GENISLIK (128)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .yaz_blok    (yaz_blok),
        .yaz_gecerli (yaz_gecerli),
        .yaz_hazir   (yaz_hazir),
        .bosalt      (bosalt),
        .blok        (blok),
        .g_gecerli   (g_gecerli),
        .hazir       (hazir),
        .seviye      (seviye)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pat(input int unsigned n);
        return {32'hC0DE0000 | n, 32'h0, 32'h1234_5678, n};
    endfunction

    logic [127:0] q[$];
    logic [4:0]   lvl;
    fifo_durum_t  st;
    logic         yv, hz, bs, w, r;
    logic [127:0] d;
    logic [5:0]   nxt;

    initial begin
        rst = 1'b1; yaz_blok = '0; yaz_gecerli = 1'b0; bosalt = 1'b0; hazir = 1'b0;
        tick();
        check("rst_seviye", 128'(seviye), 128'd0);
        check("rst_g_gecerli", 128'(g_gecerli), 128'd0);
        check("rst_yaz_hazir", 128'(yaz_hazir), 128'd0);
        rst = 1'b0;
        #1;
        check("post_rst_yaz_hazir", 128'(yaz_hazir), 128'd1);

        // Fill to full with blocks 1..16, engine not ready.
        for (int i = 1; i <= 16; i++) begin
            yaz_blok = 128'(i); yaz_gecerli = 1'b1;
            #1;
            check("fill_g_gecerli_low", 128'(g_gecerli), 128'd0);
            tick();
        end
        yaz_gecerli = 1'b0;
        check("full_g_gecerli", 128'(g_gecerli), 128'd1);
        check("full_seviye", 128'(seviye), 128'd16);
        check("full_yaz_hazir", 128'(yaz_hazir), 128'd0);
        check("full_blok", blok, 128'd1);

        // Overflow: writes while full must be ignored.
        for (int i = 0; i < 3; i++) begin
            yaz_blok = 128'hDEAD; yaz_gecerli = 1'b1; hazir = 1'b0;
            tick();
            check("ovf_seviye", 128'(seviye), 128'd16);
        end
        yaz_gecerli = 1'b0;

        // Full-rate drain, order must be 1..16.
        hazir = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            #1;
            check("drain_g_gecerli", 128'(g_gecerli), 128'd1);
            check("drain_blok", blok, 128'(i));
            tick();
        end
        hazir = 1'b0;
        check("drain_seviye", 128'(seviye), 128'd0);
        check("drain_g_gecerli_end", 128'(g_gecerli), 128'd0);
        check("drain_state", 128'(dut.durum_q), 128'(BEKLE));

        // Flush while empty is ignored.
        bosalt = 1'b1;
        tick();
        bosalt = 1'b0;
        check("empty_flush_state", 128'(dut.durum_q), 128'(BEKLE));
        check("empty_flush_g", 128'(g_gecerli), 128'd0);

        // Partial fill of 5 then flush.
        for (int i = 1; i <= 5; i++) begin
            yaz_blok = pat(i); yaz_gecerli = 1'b1;
            tick();
        end
        yaz_gecerli = 1'b0;
        check("part_g_low", 128'(g_gecerli), 128'd0);
        bosalt = 1'b1;
        tick();
        bosalt = 1'b0;
        check("flush_g_gecerli", 128'(g_gecerli), 128'd1);
        check("flush_seviye", 128'(seviye), 128'd5);
        hazir = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            check("flush_blok", blok, pat(i));
            tick();
        end
        hazir = 1'b0;
        check("flush_end_state", 128'(dut.durum_q), 128'(BEKLE));
        check("flush_end_g", 128'(g_gecerli), 128'd0);

        // Write + flush together: AKIS with one block, then write and read together.
        yaz_blok = pat(100); yaz_gecerli = 1'b1; bosalt = 1'b1;
        tick();
        bosalt = 1'b0;
        check("simul_pre_state", 128'(dut.durum_q), 128'(AKIS));
        check("simul_pre_seviye", 128'(seviye), 128'd1);
        yaz_blok = pat(101); hazir = 1'b1;
        #1;
        check("simul_blok", blok, pat(100));
        tick();
        yaz_gecerli = 1'b0; hazir = 1'b0;
        check("simul_seviye", 128'(seviye), 128'd1);
        check("simul_state", 128'(dut.durum_q), 128'(AKIS));
        check("simul_blok_next", blok, pat(101));

        // Random traffic against a reference queue and FSM model.
        q.push_back(pat(101));
        lvl = 5'd1; st = AKIS;
        for (int c = 0; c < 1000; c++) begin
            yv = 1'($urandom_range(0, 1));
            hz = 1'($urandom_range(0, 1));
            bs = ($urandom_range(0, 7) == 0);
            d  = {$urandom, $urandom, $urandom, $urandom};
            check("rnd_yaz_hazir", 128'(yaz_hazir), 128'(lvl != 5'd16));
            check("rnd_g_gecerli", 128'(g_gecerli), 128'((st == AKIS) && (lvl != 5'd0)));
            w = yv && (lvl != 5'd16);
            r = hz && (st == AKIS) && (lvl != 5'd0);
            if (r) begin
                check("rnd_blok", blok, q[0]);
                void'(q.pop_front());
            end
            if (w) q.push_back(d);
            nxt = 6'(lvl) + 6'(w) - 6'(r);
            if (st == BEKLE) begin
                if (nxt == 6'd16 || (bs && nxt != 6'd0)) st = AKIS;
            end else if (nxt == 6'd0) begin
                st = BEKLE;
            end
            lvl = nxt[4:0];
            yaz_blok = d; yaz_gecerli = yv; hazir = hz; bosalt = bs;
            tick();
        end
        yaz_gecerli = 1'b0; hazir = 1'b0; bosalt = 1'b0;
        check("rnd_seviye_end", 128'(seviye), 128'(lvl));

        // Reset mid-stream at level 9: fill 16, pop 7.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            yaz_blok = 128'(i); yaz_gecerli = 1'b1;
            tick();
        end
        yaz_gecerli = 1'b0; hazir = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        hazir = 1'b0;
        check("mid_seviye9", 128'(seviye), 128'd9);
        check("mid_blok8", blok, 128'd8);
        rst = 1'b1; yaz_gecerli = 1'b1; yaz_blok = 128'hBAD; hazir = 1'b1;
        #1;
        check("mid_rst_yaz_hazir", 128'(yaz_hazir), 128'd0);
        tick();
        rst = 1'b0; yaz_gecerli = 1'b0; hazir = 1'b0;
        check("mid_rst_seviye", 128'(seviye), 128'd0);
        check("mid_rst_g", 128'(g_gecerli), 128'd0);
        check("mid_rst_state", 128'(dut.durum_q), 128'(BEKLE));
        check("mid_rst_wr_ptr", 128'(dut.wr_ptr_q), 128'd0);
        for (int i = 1; i <= 2; i++) begin
            yaz_blok = pat(200 + i); yaz_gecerli = 1'b1;
            tick();
        end
        yaz_gecerli = 1'b0; bosalt = 1'b1;
        tick();
        bosalt = 1'b0;
        check("post_rst_wr_ptr", 128'(dut.wr_ptr_q), 128'd2);
        check("post_rst_g", 128'(g_gecerli), 128'd1);
        hazir = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            check("post_rst_blok", blok, pat(200 + i));
            tick();
        end
        hazir = 1'b0;
        check("post_rst_state", 128'(dut.durum_q), 128'(BEKLE));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/aes_giris_fifo.md
# aes_giris_fifo

Input block buffer placed directly upstream of `aes_engine`. It accepts 128-bit plaintext blocks from the producer and holds them back until the buffer is full, or until a flush is requested. It then streams them to the engine over the `g_gecerli`/`hazir` handshake. This matches the engine's "start when the FIFO is full" operating model and decouples producer bursts from engine throughput.

## Interface
- `DERINLIK`, default 16: number of block entries. Must be a power of two and at least 2.
- `GENISLIK`, default 128: block width in bits.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `yaz_blok`  in  GENISLIK: producer block.
- `yaz_gecerli`  in  1: producer has a block.
- `yaz_hazir`  out  1: FIFO can accept a block (not full).
- `bosalt`  in  1: single-cycle flush request that starts streaming a partially filled buffer.
- `blok`  out  GENISLIK: head block, connects to the engine's `blok`.
- `g_gecerli`  out  1: head block valid, connects to the engine's `g_gecerli`.
- `hazir`  in  1: engine accepts the head block this cycle.
- `seviye`  out  $clog2(DERINLIK+1): current occupancy.

## Operation
- **Write rule:** a write is accepted on an edge where `yaz_gecerli & yaz_hazir`.
- **Read rule:** a read (pop) is accepted on an edge where `g_gecerli & hazir`.
- **Storage:** circular buffer with write pointer, read pointer and occupancy counter. Pointers are $clog2(DERINLIK) bits and wrap naturally from DERINLIK-1 to 0.
- **Occupancy update:** `seviye_next = seviye + write - read`. A simultaneous write and read leaves `seviye` unchanged.
- **`yaz_hazir`** = (`seviye` != DERINLIK). A write attempted while full is ignored; no overwrite occurs.
- **State machine:**
  - BEKLE (fill): `g_gecerli` = 0.
    - → AKIS when `seviye_next` == DERINLIK.
    - → AKIS when `bosalt` = 1 and `seviye_next` > 0.
    - `bosalt` with an empty buffer and no write is ignored.
  - AKIS (stream): `g_gecerli` = (`seviye` != 0).
    - → BEKLE when `seviye_next` == 0.
    - Stays in AKIS if a write and the last read occur together.
    - `bosalt` has no effect in AKIS.
- **`blok`** = `mem[rd_ptr]` (first-word fall-through). It is stable while `g_gecerli` = 1 and `hazir` = 0. It is don't-care while `g_gecerli` = 0.
- **Ordering:** strict FIFO; no reordering or duplication.

## Timing
- **Reset:**
  - state BEKLE; pointers 0; `seviye` 0.
  - `g_gecerli` 0; `yaz_hazir` 0 during reset, 1 from the first cycle after reset deasserts.
  - Memory contents are not reset.
- **Reset mid-operation:** all buffered blocks are discarded and the block returns to the reset state on the next edge. A write or read coincident with `rst` is not accepted.
- **Fill latency:** `g_gecerli` rises in the cycle after the edge that accepts the DERINLIK-th write.
- **Flush latency:** `g_gecerli` rises in the cycle after the edge that samples `bosalt`.
- **Full-rate streaming:** with `hazir` held high, one block is popped per cycle; DERINLIK blocks drain in DERINLIK cycles.
- **When full, with a pop in the same cycle:** the write is still refused, because `yaz_hazir` is computed from the registered `seviye` with no combinational path from `hazir`.
- **Re-arm:** the BEKLE → AKIS → BEKLE cycle repeats indefinitely.

## Structure
- **Shared package `aes_pkg`:**
  - `BLOK_W` = 128.
  - The state enum {BEKLE, AKIS}.
  - The default depth constant, shared with `aes_engine` and the wrapper.
- **Sub-module `aes_fifo_bellek`:** simple dual-port RAM with a synchronous write port and an asynchronous read port, parameterised by depth and width, so it can map to distributed RAM. Control, pointers, counter and FSM stay in `aes_giris_fifo`.

## Test plan
- **Fill to full:** reset, then write 16 blocks 1..16 in consecutive cycles with `hazir` = 0.
  - `g_gecerli` = 0 through the 16th write, then 1 on the next cycle.
  - `seviye` = 16, `yaz_hazir` = 0, `blok` = 1.
- **Drain at full rate:** from full, hold `hazir` = 1 for 16 cycles.
  - `blok` sequence is 1..16.
  - `seviye` reaches 0, then `g_gecerli` = 0 and state is BEKLE.
- **Overflow:** from full, drive `yaz_gecerli` = 1 with `hazir` = 0 for 3 cycles.
  - No write accepted; `seviye` stays 16; output order unchanged.
- **Flush:** write 5 blocks, then pulse `bosalt`.
  - `g_gecerli` = 1 on the next cycle; 5 blocks come out in order, then BEKLE.
  - `bosalt` pulsed while empty → no state change.
- **Simultaneous traffic:** in AKIS with `seviye` = 1, write and read in the same cycle.
  - `seviye` stays 1 and state stays AKIS.
  - Continue random write/read traffic for 1000 cycles: every block is delivered exactly once, in order, checked against a reference queue; pointers wrap past 15.
- **Reset mid-stream:** assert `rst` for 1 cycle while `seviye` = 9.
  - Next cycle: `seviye` = 0, `g_gecerli` = 0, state BEKLE.
  - Subsequent blocks are accepted starting at pointer 0.
